// File: rtl/fsm_walk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fsm_walk_pkg                                                    |
// | Purpose  : Shared definitions for the FSM walk sequencer.                  |
// |            - State codes of the target x/y FSM (A..H = 0..7).              |
// |            - Sequencer state encoding.                                     |
// |            - drive_sel(): picks the x or y pulse that advances the FSM     |
// |              one hop toward the requested target.                          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package fsm_walk_pkg;

  localparam logic [2:0] ST_A = 3'd0;
  localparam logic [2:0] ST_B = 3'd1;
  localparam logic [2:0] ST_C = 3'd2;
  localparam logic [2:0] ST_D = 3'd3;
  localparam logic [2:0] ST_E = 3'd4;
  localparam logic [2:0] ST_F = 3'd5;
  localparam logic [2:0] ST_G = 3'd6;
  localparam logic [2:0] ST_H = 3'd7;

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_CHECK  = 3'd1,
    SEQ_DRIVE  = 3'd2,
    SEQ_SETTLE = 3'd3,
    SEQ_DONE   = 3'd4,
    SEQ_ERR    = 3'd5
  } seq_state_e;

  // Returns {x, y}. Only A and C have a y edge worth taking; everywhere
  // else the x edge moves the FSM along its main loop toward the target.
  function automatic logic [1:0] drive_sel(input logic [2:0] sta,
                                           input logic [2:0] target);
    logic [1:0] sel;
    sel = 2'b10;
    case (sta)
      ST_A: if (target == ST_E || target == ST_F) sel = 2'b01;
      ST_C: if (target == ST_G || target == ST_H) sel = 2'b01;
      default: sel = 2'b10;
    endcase
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fsm_walk_settle_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fsm_walk_settle_timer                                           |
// | Purpose  : Load / count-down / expire counter used to hold the sequencer   |
// |            in SETTLE for LOAD_VAL cycles after each drive pulse.           |
// | Ports    : i_clk    clock                                                  |
// |            i_rst    synchronous active-high reset                          |
// |            i_load   load counter with LOAD_VAL                             |
// |            i_dec    decrement counter by one                               |
// |            o_expire high when the current cycle is the last one to wait    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fsm_walk_settle_timer #(
  parameter int CNT_W    = 4,
  parameter int LOAD_VAL = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_dec,
  output logic o_expire
);

  localparam logic [CNT_W-1:0] C_LOAD = CNT_W'(LOAD_VAL);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = C_LOAD;
    end else if (i_dec && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Loaded with N on entry, so N waiting cycles see N, N-1, ..., 1.
  assign o_expire = (cnt_q <= CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/fsm_walk_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fsm_walk_sequencer                                              |
// | Purpose  : Walks the 8-state x/y FSM from its present state to a           |
// |            requested target, one x or y pulse at a time, then pulses       |
// |            o_done (arrived) or o_err (step limit / stall).                 |
// | Ports    : i_clk, i_rst         clock, synchronous active-high reset       |
// |            i_req_valid/_target  target request (valid/ready handshake)     |
// |            o_req_ready          high only while idle                       |
// |            i_sta                FSM present state                          |
// |            o_x, o_y             drive pulses into the FSM                  |
// |            o_busy               high while a request is in progress        |
// |            o_done, o_err        one-cycle completion pulses                |
// |            o_steps              pulses issued for last/current request     |
// | Options  : FSM_WALK_STALL_CHK_EN  abort when the FSM does not move after   |
// |                                   a pulse                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fsm_walk_sequencer
  import fsm_walk_pkg::*;
#(
  parameter int MAX_STEPS  = 8,
  parameter int STEP_W     = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  input  logic [2:0]        i_req_target,
  output logic              o_req_ready,
  input  logic [2:0]        i_sta,
  output logic              o_x,
  output logic              o_y,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [STEP_W-1:0] o_steps
);

  localparam logic [STEP_W-1:0] C_MAX_STEPS = STEP_W'(MAX_STEPS);

  seq_state_e        state_q, state_d;
  logic [2:0]        target_q, target_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic              x_q, x_d;
  logic              y_q, y_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;

  logic              timer_load;
  logic              timer_dec;
  logic              timer_expire;
  logic              stall;

  fsm_walk_settle_timer #(
    .CNT_W    (4),
    .LOAD_VAL (SETTLE_CYC)
  ) u_settle_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_load   (timer_load),
    .i_dec    (timer_dec),
    .o_expire (timer_expire)
  );

`ifdef FSM_WALK_STALL_CHK_EN
  // State seen while the last pulse was on the wire; if the FSM is still
  // there after settling, it ignored the pulse.
  logic [2:0] prev_sta_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_sta_q <= ST_A;
    end else if (state_q == SEQ_DRIVE) begin
      prev_sta_q <= i_sta;
    end
  end

  assign stall = (steps_q != '0) && (i_sta == prev_sta_q);
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    steps_d    = steps_q;
    x_d        = 1'b0;
    y_d        = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    timer_load = 1'b0;
    timer_dec  = 1'b0;

    case (state_q)
      SEQ_IDLE: begin
        if (i_req_valid) begin
          target_d = i_req_target;
          steps_d  = '0;
          state_d  = SEQ_CHECK;
        end
      end
      SEQ_CHECK: begin
        if (i_sta == target_q) begin
          done_d  = 1'b1;
          state_d = SEQ_DONE;
        end else if (stall || steps_q == C_MAX_STEPS) begin
          err_d   = 1'b1;
          state_d = SEQ_ERR;
        end else begin
          // Registered so the pulse is high for exactly the DRIVE cycle.
          {x_d, y_d} = drive_sel(i_sta, target_q);
          state_d    = SEQ_DRIVE;
        end
      end
      SEQ_DRIVE: begin
        steps_d    = steps_q + STEP_W'(1);
        timer_load = 1'b1;
        state_d    = SEQ_SETTLE;
      end
      SEQ_SETTLE: begin
        if (timer_expire) begin
          state_d = SEQ_CHECK;
        end else begin
          timer_dec = 1'b1;
        end
      end
      SEQ_DONE: state_d = SEQ_IDLE;
      SEQ_ERR:  state_d = SEQ_IDLE;
      default:  state_d = SEQ_IDLE;
    endcase

    busy_d  = (state_d != SEQ_IDLE);
    ready_d = (state_d == SEQ_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= SEQ_IDLE;
      target_q <= 3'd0;
      steps_q  <= '0;
      x_q      <= 1'b0;
      y_q      <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      steps_q  <= steps_d;
      x_q      <= x_d;
      y_q      <= y_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  assign o_req_ready = ready_q;
  assign o_x         = x_q;
  assign o_y         = y_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_steps     = steps_q;

endmodule
`default_nettype wire

// File: tb/tb_fsm_walk_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fsm_walk_sequencer                                           |
// | Purpose  : Self-checking bench for fsm_walk_sequencer. A behavioural x/y   |
// |            FSM plant answers the pulses; a reference walk computed from    |
// |            the routing rules gives the expected pulse list, outcome and    |
// |            timing. Honours FSM_WALK_STALL_CHK_EN.                          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_fsm_walk_sequencer;

  localparam int MAXS   = 8;
  localparam int SET    = 1;
  localparam int BUDGET = 2 + (2 + SET) * (MAXS + 2);
`ifdef FSM_WALK_STALL_CHK_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [2:0] req_target;
  logic       req_ready;
  logic [2:0] sta;
  logic       x, y, busy, done, err;
  logic [3:0] steps;

  always #5 clk = ~clk;

  fsm_walk_sequencer #(.MAX_STEPS(MAXS), .STEP_W(4), .SETTLE_CYC(SET)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_target(req_target),
    .o_req_ready(req_ready), .i_sta(sta), .o_x(x), .o_y(y), .o_busy(busy),
    .o_done(done), .o_err(err), .o_steps(steps)
  );

  // ---------------- plant: the lab x/y FSM --------------------------------
  // x edges: A->B->D->C->A, E->F->G->H->A ; y edges: A->E, C->G ; 00 holds.
  int x_succ [8] = '{1, 3, 0, 2, 5, 6, 7, 0};
  int y_succ [8] = '{4, 1, 6, 3, 4, 5, 6, 7};

  logic       plant_load;
  logic [2:0] plant_val;
  logic       plant_freeze;

  always @(posedge clk) begin
    if (plant_load)                sta <= plant_val;
    else if (!plant_freeze && x && !y) sta <= 3'(x_succ[sta]);
    else if (!plant_freeze && y && !x) sta <= 3'(y_succ[sta]);
  end

  // ---------------- reference walk ----------------------------------------
  int exp_seq [16];   // 1 = x pulse, 2 = y pulse
  int exp_n;
  bit exp_err;

  function automatic int rule(input int s, input int t);
    if (s == 0 && (t == 4 || t == 5)) return 2;
    if (s == 2 && (t == 6 || t == 7)) return 2;
    return 1;
  endfunction

  task automatic ref_walk(input int start, input int target, input bit frozen);
    int s;
    int c;
    s = start;
    exp_n = 0;
    exp_err = 1'b0;
    while (s != target) begin
      // A frozen plant never moves, so the stall check trips after one pulse.
      if (exp_n == MAXS || (STALL && frozen && exp_n > 0)) begin
        exp_err = 1'b1;
        break;
      end
      c = rule(s, target);
      exp_seq[exp_n] = c;
      exp_n++;
      if (!frozen) s = (c == 1) ? x_succ[s] : y_succ[s];
    end
  endtask

  // ---------------- checking ----------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_run(input string name, input int start, input int target, input bit frozen);
    int obs [32];
    int npul;
    int end_at;
    bit saw_done;
    bit saw_err;
    int hs_bad;
    plant_val  = 3'(start);
    plant_load = 1'b1;
    step();
    plant_load   = 1'b0;
    plant_freeze = frozen;
    ref_walk(start, target, frozen);
    check({name, " ready_idle"}, 32'(req_ready), 1);
    req_valid  = 1'b1;
    req_target = 3'(target);
    step();
    req_valid = 1'b0;
    npul = 0; end_at = -1; saw_done = 0; saw_err = 0; hs_bad = 0;
    for (int k = 1; k <= BUDGET; k++) begin
      if (x || y) begin
        if (npul < 32) obs[npul] = (x && y) ? 3 : (x ? 1 : 2);
        npul++;
      end
      if (!busy || req_ready) hs_bad++;
      if (done || err) begin
        saw_done = done;
        saw_err  = err;
        end_at   = k;
        break;
      end
      step();
    end
    check({name, " terminated"}, 32'(end_at > 0), 1);
    check({name, " pulse_count"}, 32'(npul), 32'(exp_n));
    for (int i = 0; i < exp_n && i < npul && i < 32; i++)
      check({name, " pulse_kind"}, 32'(obs[i]), 32'(exp_seq[i]));
    check({name, " done"}, 32'(saw_done), 32'(!exp_err));
    check({name, " err"}, 32'(saw_err), 32'(exp_err));
    check({name, " latency"}, 32'(end_at), 32'(2 + (2 + SET) * exp_n));
    check({name, " steps"}, 32'(steps), 32'(exp_n));
    check({name, " busy_handshake"}, 32'(hs_bad), 0);
    step();
    check({name, " back_ready"}, 32'(req_ready), 1);
    check({name, " back_idle"}, 32'({busy, done, err, x, y}), 0);
    check({name, " steps_hold"}, 32'(steps), 32'(exp_n));
    if (!exp_err) check({name, " plant_at_target"}, 32'(sta), 32'(target));
    plant_freeze = 1'b0;
  endtask

  initial begin
    int s, t;
    int bad;
    rst = 1'b1; req_valid = 1'b0; req_target = 3'd0;
    plant_load = 1'b1; plant_val = 3'd0; plant_freeze = 1'b0;
    step(); step();
    check("reset_outputs", 32'({x, y, busy, done, err}), 0);
    check("reset_steps", 32'(steps), 0);
    check("reset_ready", 32'(req_ready), 1);
    rst = 1'b0;
    plant_load = 1'b0;
    step();

    do_run("A_to_D", 0, 3, 1'b0);
    do_run("A_to_G", 0, 6, 1'b0);
    do_run("C_to_F", 2, 5, 1'b0);
    do_run("B_to_B", 1, 1, 1'b0);
    do_run("A_to_H", 0, 7, 1'b0);
    do_run("frozen_A_to_H", 0, 7, 1'b1);

    for (int r = 0; r < 6; r++) begin
      s = int'($urandom_range(0, 7));
      t = int'($urandom_range(0, 7));
      do_run("random", s, t, 1'b0);
    end

    // Reset while in SETTLE: next cycle idle, everything zero, no pulses after.
    plant_val = 3'd0; plant_load = 1'b1;
    step();
    plant_load = 1'b0;
    req_valid = 1'b1; req_target = 3'd7;
    step();                 // CHECK
    req_valid = 1'b0;
    step();                 // DRIVE
    check("mid_drive_pulse", 32'(x), 1);
    step();                 // SETTLE
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid_outputs", 32'({x, y, busy, done, err}), 0);
    check("rst_mid_steps", 32'(steps), 0);
    check("rst_mid_ready", 32'(req_ready), 1);
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (x || y || done || err || busy) bad++;
    end
    check("rst_mid_quiet", 32'(bad), 0);

    do_run("after_reset", 2, 4, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
